// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider for RV32M DIV/DIVU/REM/REMU.
// The quotient and remainder come from restoring radix-2 division, one bit
// per cycle. Division by zero and signed overflow finish one cycle after the
// request is latched.

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV  2'b00
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 2'b01
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM  2'b10
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 2'b11
`endif

module div_unit (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     div_valid,
  output logic                     div_ready,
  input  logic [`DIV_OP_WIDTH-1:0] DIVop,
  input  logic [31:0]              divident,
  input  logic [31:0]              divisor,
  output logic [31:0]              div_result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [`DIV_OP_WIDTH-1:0] op_q;
  logic [31:0] quo_q;      // holds |dividend| and shifts in quotient bits
  logic [31:0] dvs_q;      // |divisor|
  logic [32:0] rem_q;      // partial remainder
  logic [5:0]  cnt_q;
  logic        q_neg_q;
  logic        r_neg_q;

  // Incoming request decode, used only in the latch cycle
  logic        in_signed, in_rem_op, in_dvd_neg, in_dvs_neg;
  logic        in_zero, in_ovf, in_special;
  logic [31:0] in_dvd_abs, in_dvs_abs, special_res;

  // One restoring iteration and final sign fix-up
  logic        rem_op_q, q_bit;
  logic [32:0] rem_shift, trial, rem_next;
  logic [31:0] quo_next, q_fin, r_fin, calc_res;

  // Operand decode: signs, magnitudes and the two early-exit cases
  always_comb begin
    in_signed   = (DIVop == `DIV_OP_DIV) || (DIVop == `DIV_OP_REM);
    in_rem_op   = (DIVop == `DIV_OP_REM) || (DIVop == `DIV_OP_REMU);
    in_dvd_neg  = in_signed & divident[31];
    in_dvs_neg  = in_signed & divisor[31];
    in_dvd_abs  = in_dvd_neg ? (32'd0 - divident) : divident;
    in_dvs_abs  = in_dvs_neg ? (32'd0 - divisor) : divisor;
    in_zero     = (divisor == '0);
    in_ovf      = in_signed && (divident == 32'h8000_0000) && (divisor == '1);
    in_special  = in_zero | in_ovf;
    if (in_zero)
      special_res = in_rem_op ? divident : '1;
    else
      special_res = in_rem_op ? '0 : 32'h8000_0000;
  end

  // Restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_op_q  = (op_q == `DIV_OP_REM) || (op_q == `DIV_OP_REMU);
    rem_shift = {rem_q[31:0], quo_q[31]};
    trial     = rem_shift - {1'b0, dvs_q};
    q_bit     = ~trial[32];
    rem_next  = q_bit ? trial : rem_shift;
    quo_next  = {quo_q[30:0], q_bit};
    q_fin     = q_neg_q ? (32'd0 - quo_next) : quo_next;
    r_fin     = r_neg_q ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
    calc_res  = rem_op_q ? r_fin : q_fin;
  end

  // Next-state logic; div_ready decodes straight from the state register
  always_comb begin
    state_nxt = state;
    div_ready = 1'b0;
    unique case (state)
      IDLE: if (div_valid) state_nxt = in_special ? DONE : CALC;
      CALC: begin
        if (!div_valid)
          state_nxt = IDLE;
        else if (cnt_q == 6'd31)
          state_nxt = DONE;
      end
      DONE: begin
        div_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand latches, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      op_q       <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_result <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (div_valid) begin
            op_q    <= DIVop;
            quo_q   <= in_dvd_abs;
            dvs_q   <= in_dvs_abs;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= in_dvd_neg ^ in_dvs_neg;
            r_neg_q <= in_dvd_neg;
            if (in_special)
              div_result <= special_res;
          end
        end
        CALC: begin
          if (div_valid) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            cnt_q <= cnt_q + 6'd1;
            // Result is registered on the final iteration so it is
            // already valid during the DONE cycle.
            if (cnt_q == 6'd31)
              div_result <= calc_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized
// operations against an arithmetic reference model, reset and abort.

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV  2'b00
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 2'b01
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM  2'b10
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 2'b11
`endif

module tb_div_unit;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic                     div_valid;
  logic                     div_ready;
  logic [`DIV_OP_WIDTH-1:0] DIVop;
  logic [31:0]              divident;
  logic [31:0]              divisor;
  logic [31:0]              div_result;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .DIVop      (DIVop),
    .divident   (divident),
    .divisor    (divisor),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  function automatic bit is_signed_op(input logic [`DIV_OP_WIDTH-1:0] op);
    return (op == `DIV_OP_DIV) || (op == `DIV_OP_REM);
  endfunction

  function automatic bit is_rem_op(input logic [`DIV_OP_WIDTH-1:0] op);
    return (op == `DIV_OP_REM) || (op == `DIV_OP_REMU);
  endfunction

  // Reference: plain 64-bit arithmetic; truncating division gives the
  // RISC-V sign rules, and -2^31 / -1 wraps to 0x80000000 naturally.
  function automatic logic [31:0] ref_div(input logic [`DIV_OP_WIDTH-1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0)
      return is_rem_op(op) ? a : 32'hFFFF_FFFF;
    if (is_signed_op(op)) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return is_rem_op(op) ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_latency(input logic [`DIV_OP_WIDTH-1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // One full operation from IDLE; returns in IDLE at a sample point.
  task automatic run_op(input logic [`DIV_OP_WIDTH-1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] exp_res, prev;
    int exp_lat, lat;
    bit seen, stable;
    exp_res = ref_div(op, a, b);
    exp_lat = ref_latency(op, a, b);
    prev    = div_result;
    DIVop = op; divident = a; divisor = b; div_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble operands after the latch edge; they must be ignored
    divident = $urandom; divisor = $urandom;
    DIVop = `DIV_OP_WIDTH'($urandom_range(0, 3));
    seen = 0; stable = 1; lat = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (div_ready === 1'b1) begin
        seen = 1; lat = c;
      end else if (div_result !== prev) begin
        stable = 0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no div_ready within 40 cycles", name);
    end else begin
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (div_result !== exp_res) begin
        errors++;
        $display("FAIL %s result: got %h expected %h (op %0d a %h b %h)",
                 name, div_result, exp_res, op, a, b);
      end
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s stability: div_result changed before div_ready", name);
    end
    div_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (div_ready !== 1'b0 || div_result !== exp_res) begin
      errors++;
      $display("FAIL %s after_done: ready %b result %h expected ready 0 result %h",
               name, div_ready, div_result, exp_res);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; div_valid = 1'b0; DIVop = '0; divident = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (div_ready !== 1'b0 || div_result !== 32'd0) begin
      errors++;
      $display("FAIL reset: ready %b result %h expected ready 0 result 00000000",
               div_ready, div_result);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(`DIV_OP_DIVU, 32'd100,        32'd7,          "divu_100_7");
    run_op(`DIV_OP_REMU, 32'd100,        32'd7,          "remu_100_7");
    run_op(`DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          "div_m7_2");
    run_op(`DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          "rem_m7_2");
    run_op(`DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  "div_7_m2");
    run_op(`DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  "rem_7_m2");
    run_op(`DIV_OP_DIVU, 32'd5,          32'd0,          "divu_5_0");
    run_op(`DIV_OP_REMU, 32'd5,          32'd0,          "remu_5_0");
    run_op(`DIV_OP_DIV,  32'd5,          32'd0,          "div_5_0");
    run_op(`DIV_OP_REM,  32'hFFFF_FFF0,  32'd0,          "rem_m16_0");
    run_op(`DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  "div_ovf");
    run_op(`DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  "rem_ovf");
    run_op(`DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  "divu_big");
    run_op(`DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          "divu_max_1");
    run_op(`DIV_OP_DIV,  32'h8000_0000,  32'd1,          "div_min_1");
  endtask

  task automatic test_random();
    logic [`DIV_OP_WIDTH-1:0] op;
    logic [31:0] a, b;
    int sel;
    for (int i = 0; i < 40; i++) begin
      op  = `DIV_OP_WIDTH'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0 - $urandom_range(1, 15);
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  task automatic test_reset_mid_calc();
    bit ready_seen;
    run_op(`DIV_OP_DIVU, 32'd100, 32'd7, "pre_reset");
    DIVop = `DIV_OP_DIVU; divident = 32'd1000; divisor = 32'd3; div_valid = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    // now in CALC cycle 10
    resetn = 1'b0; div_valid = 1'b0;
    ready_seen = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (div_ready === 1'b1) ready_seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (ready_seen || div_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: ready_seen %0d result %h expected 0 and 00000000",
               ready_seen, div_result);
    end
    run_op(`DIV_OP_DIVU, 32'd9, 32'd3, "post_reset_9_3");
  endtask

  task automatic test_abort();
    bit ready_seen;
    run_op(`DIV_OP_REMU, 32'd100, 32'd7, "pre_abort");
    DIVop = `DIV_OP_DIVU; divident = 32'd5000; divisor = 32'd9; div_valid = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    // now in CALC cycle 5
    div_valid = 1'b0;
    ready_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (div_ready === 1'b1) ready_seen = 1;
    end
    checks++;
    if (ready_seen || div_result !== 32'd2) begin
      errors++;
      $display("FAIL abort: ready_seen %0d result %h expected 0 and 00000002",
               ready_seen, div_result);
    end
    run_op(`DIV_OP_DIV, 32'hFFFF_FF00, 32'd16, "post_abort");
  endtask

  task automatic test_back_to_back();
    run_op(`DIV_OP_DIVU, 32'd12345678, 32'd1000, "b2b_0");
    run_op(`DIV_OP_REMU, 32'd0,        32'd0,    "b2b_1");
    run_op(`DIV_OP_REM,  32'd12345678, 32'd1000, "b2b_2");
    run_op(`DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "b2b_3");
    run_op(`DIV_OP_DIVU, 32'd1,        32'hFFFF_FFFF, "b2b_4");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_calc();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports listed as name  direction  width  meaning:
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 div_valid  input  1  request from the control unit; held high until div_ready is seen.
REQ-005 div_ready  output  1  one-cycle completion pulse; result is valid in that cycle.
REQ-006 DIVop  input  `DIV_OP_WIDTH  operation select using the riscv_defines.svh DIV_OP_* constants: DIV, DIVU, REM, REMU.
REQ-007 divident  input  32  rs1 operand (dividend).
REQ-008 divisor  input  32  rs2 operand.
REQ-009 div_result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-010 The FSM SHALL use states IDLE, CALC and DONE.
REQ-011 In IDLE with div_valid=1, the block SHALL latch DIVop, divident and divisor (cycle 0); later operand changes SHALL be ignored.
REQ-012 Signed ops (DIV, REM) SHALL divide the absolute values; the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-013 Unsigned ops (DIVU, REMU) SHALL treat both operands as unsigned 32-bit values.
REQ-014 On a normal start, IDLE->CALC; CALC SHALL run exactly 32 restoring radix-2 iterations, one quotient bit per cycle, MSB first, using a 33-bit partial remainder.
REQ-015 After iteration 32, CALC->DONE; div_ready=1 in DONE, i.e. in cycle 33 counted from the latch cycle; DONE->IDLE unconditionally after one cycle.
REQ-016 Divisor==0 SHALL be a special case (no CALC): IDLE->DONE with div_ready in cycle 1; quotient=0xFFFFFFFF for both DIV and DIVU; remainder=dividend unchanged.
REQ-017 Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF) SHALL be a special case: IDLE->DONE, ready in cycle 1, quotient=0x80000000, remainder=0.
REQ-018 div_ready SHALL be high for exactly one cycle per completed operation and never high in IDLE or CALC.
REQ-019 div_result SHALL be written in the DONE cycle and held stable until the next DONE or reset.
REQ-020 If div_valid falls while in CALC, the block SHALL abort to IDLE on the next edge, assert no div_ready, and leave div_result unchanged.
REQ-021 A new operation SHALL start only from IDLE; the control unit deasserts div_valid in the cycle after div_ready, so no back-to-back start from DONE exists.
REQ-022 The iteration counter SHALL be 6 bits, SHALL be cleared on entry to CALC, and SHALL not wrap during an operation.
REQ-023 Combinational outputs SHALL have no path from div_valid to div_ready; div_ready SHALL be a registered or state-decoded signal.

Reset
REQ-024 With resetn=0 at a rising edge: state=IDLE, div_ready=0, div_result=0x00000000, counter=0, and latched operands cleared.
REQ-025 Reset SHALL take priority over every transition, including mid-CALC and in DONE; an operation interrupted by reset produces no div_ready.

Verification
REQ-026 DIVU 100/7 -> div_ready only in cycle 33, div_result=14; REMU 100/7 -> 2.
REQ-027 DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1); DIV 7/0xFFFFFFFE(-2) -> 0xFFFFFFFD, REM -> 1.
REQ-028 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with div_ready in cycle 1.
REQ-029 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each with div_ready in cycle 1.
REQ-030 resetn low at CALC cycle 10 -> no div_ready, div_result=0; a following DIVU 9/3 -> 3 in cycle 33.
REQ-031 div_valid dropped at CALC cycle 5 -> IDLE, no div_ready, previous div_result retained; a subsequent request completes normally.
